// File: rtl/serial_mag_comp_ctrl_if.sv
// rtl/serial_mag_comp_ctrl_if.sv - request/result bundle for the serial magnitude comparator
interface serial_mag_comp_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int DW = $clog2(WIDTH / 2) + 1;

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_eq_b;
  logic             a_lt_b;
  logic             a_gt_b;
  logic [DW-1:0]    digits;

  modport master (
    output start, abort, a, b,
    input  busy, done, a_eq_b, a_lt_b, a_gt_b, digits
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, a_eq_b, a_lt_b, a_gt_b, digits
  );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// rtl/serial_mag_comp_ctrl.sv - unsigned magnitude compare, one 2-bit digit per cycle, MSB first
// Stops at the first unequal digit pair; digits reports how many pairs were examined.
module serial_mag_comp_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_mag_comp_ctrl_if.slave   bus
);
  localparam int ND = WIDTH / 2;
  localparam int IW = $clog2(ND);
  localparam int DW = IW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [DW-1:0]    digits_q, digits_d;

  logic [1:0]       dig_a, dig_b;
  logic [DW-1:0]    digit_pos;

  assign dig_a     = a_q[{idx_q, 1'b0} +: 2];
  assign dig_b     = b_q[{idx_q, 1'b0} +: 2];
  // idx counts down from the MSB digit, so the 1-based position is ND - idx
  assign digit_pos = DW'(ND) - {1'b0, idx_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      digits_q <= digits_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    eq_d     = eq_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    digits_d = digits_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IW'(ND - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (bus.abort) begin
          busy_d   = 1'b0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          digits_d = '0;
          state_d  = IDLE;
        end else if (dig_a != dig_b) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          eq_d     = 1'b0;
          lt_d     = (dig_a < dig_b);
          gt_d     = (dig_a > dig_b);
          digits_d = digit_pos;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          eq_d     = 1'b1;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          digits_d = digit_pos;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_lt_b = lt_q;
  assign bus.a_gt_b = gt_q;
  assign bus.digits = digits_q;
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb/tb_serial_mag_comp_ctrl.sv - random and directed checks of serial_mag_comp_ctrl against a reference model
module tb_serial_mag_comp_ctrl;
  localparam int W  = 16;
  localparam int ND = W / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  serial_mag_comp_ctrl_if #(.WIDTH(W)) bus();
  serial_mag_comp_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // position (1-based from the MSB) of the first differing digit, ND when equal
  function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 1; i <= ND; i++)
      if (((x >> (W - 2 * i)) & 3) != ((y >> (W - 2 * i)) & 3)) return i;
    return ND;
  endfunction

  // Reference: a comparison accepted from idle finishes first_diff() edges later
  logic         m_busy, m_done, m_eq, m_lt, m_gt;
  int           m_dig, m_k, m_left;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_eq <= 0; m_lt <= 0; m_gt <= 0;
      m_dig <= 0; m_left <= 0; m_k <= 0; m_a <= '0; m_b <= '0;
    end else begin
      m_done <= 0;
      if (m_busy) begin
        if (bus.abort) begin
          m_busy <= 0; m_eq <= 0; m_lt <= 0; m_gt <= 0; m_dig <= 0;
        end else if (m_left == 1) begin
          m_busy <= 0; m_done <= 1;
          m_eq <= (m_a == m_b); m_lt <= (m_a < m_b); m_gt <= (m_a > m_b);
          m_dig <= m_k;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (!m_done && bus.start) begin
        m_a <= bus.a; m_b <= bus.b;
        m_k <= first_diff(bus.a, bus.b);
        m_left <= first_diff(bus.a, bus.b);
        m_busy <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("a_eq_b", 32'(bus.a_eq_b), 32'(m_eq));
      chk("a_lt_b", 32'(bus.a_lt_b), 32'(m_lt));
      chk("a_gt_b", 32'(bus.a_gt_b), 32'(m_gt));
      chk("digits", 32'(bus.digits), 32'(m_dig));
      if (bus.done)
        chk("onehot", 32'(bus.a_eq_b) + 32'(bus.a_lt_b) + 32'(bus.a_gt_b), 32'd1);
    end
  end

  // Called at a negedge; returns edges from the start edge to done, and busy cycles seen
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int abort_at,
                         input bit junk, output int lat, output int busy_n);
    int n;
    bus.start = 1; bus.abort = 0; bus.a = ta; bus.b = tb_v;
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom);
      bus.abort = (n == abort_at);
      if (bus.busy) busy_n++;
    end while (!bus.done && bus.busy && n < 40);
    if (n >= 40) chk("timeout", 32'(n), 32'd0);
    lat = n - 1;
    if (bus.done) bus.abort = 1'($urandom_range(0, 1));
    else bus.start = 0;
    @(negedge clk);
    bus.start = 0; bus.abort = 0;
  endtask

  initial begin
    int lat, bn, ab;
    bit seen;
    logic [W-1:0] ra, rb;
    bus.start = 0; bus.abort = 0; bus.a = '0; bus.b = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_flags", {29'd0, bus.a_eq_b, bus.a_lt_b, bus.a_gt_b}, 32'd0);
    chk("rst_digits", 32'(bus.digits), 32'd0);
    rst = 0;

    run_one(16'h8000, 16'h7FFF, 0, 0, lat, bn);
    chk("gt_lat", 32'(lat), 32'd1);
    chk("gt_flag", 32'(bus.a_gt_b), 32'd1);
    chk("gt_digits", 32'(bus.digits), 32'd1);
    chk("gt_busy_cycles", 32'(bn), 32'd1);

    run_one(16'h0001, 16'h0002, 0, 0, lat, bn);
    chk("lt_lat", 32'(lat), 32'd8);
    chk("lt_flag", 32'(bus.a_lt_b), 32'd1);
    chk("lt_digits", 32'(bus.digits), 32'd8);

    run_one(16'h1234, 16'h1234, 0, 1, lat, bn);
    chk("eq_lat", 32'(lat), 32'd8);
    chk("eq_flags", {29'd0, bus.a_eq_b, bus.a_lt_b, bus.a_gt_b}, 32'h4);
    chk("eq_digits", 32'(bus.digits), 32'd8);

    bus.start = 1; bus.a = 16'h0001; bus.b = 16'h0002;
    seen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      seen |= bus.done;
      bus.start = (c == 3); bus.abort = (c == 5);
      if (c == 3) begin bus.a = 16'hFFFF; bus.b = 16'h0000; end
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_flags", {29'd0, bus.a_eq_b, bus.a_lt_b, bus.a_gt_b}, 32'd0);
    chk("abort_digits", 32'(bus.digits), 32'd0);
    bus.abort = 0;
    @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);

    bus.start = 1; bus.a = 16'h0003; bus.b = 16'h0003;
    @(negedge clk); bus.start = 0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_flags", {29'd0, bus.a_eq_b, bus.a_lt_b, bus.a_gt_b}, 32'd0);
    chk("arst_digits", 32'(bus.digits), 32'd0);
    @(negedge clk);
    rst = 0;
    run_one(16'h4000, 16'h0000, 0, 0, lat, bn);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_gt", 32'(bus.a_gt_b), 32'd1);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0: rb = W'($urandom);
        1: rb = ra;
        default: rb = ra ^ (W'($urandom_range(1, 3)) << (2 * $urandom_range(0, ND - 1)));
      endcase
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_one(ra, rb, ab, 1'($urandom_range(0, 1)), lat, bn);
      if (ab == 0) begin
        chk("rnd_lat", 32'(lat), 32'(first_diff(ra, rb)));
        chk("rnd_flags", {29'd0, bus.a_eq_b, bus.a_lt_b, bus.a_gt_b},
            {29'd0, ra == rb, ra < rb, ra > rb});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
